// File: rtl/vx_dcache_responder_pkg.sv
// Shared widths and the response beat bundle for the dcache responder.
// The beat carries the lane mask, one tag and per-lane read data.
package vx_dcache_responder_pkg;

  localparam int NUM_LANES = 4;
  localparam int TAG_WIDTH = 8;
  localparam int WORD_W    = 32;
  localparam int BYTES_W   = WORD_W / 8;
  localparam int ADDR_W    = 30;

  typedef logic [NUM_LANES-1:0]                lmask_t;
  typedef logic [NUM_LANES-1:0][TAG_WIDTH-1:0] ltags_t;

  typedef struct packed {
    lmask_t                             tmask;
    logic [TAG_WIDTH-1:0]               tag;
    logic [NUM_LANES-1:0][WORD_W-1:0]   data;
  } beat_t;

  // Tag of the lowest set lane in m, zero when m is empty.
  function automatic logic [TAG_WIDTH-1:0] low_tag(
    input lmask_t m,
    input ltags_t tags
  );
    logic [TAG_WIDTH-1:0] t;
    t = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i]) t = tags[i];
    return t;
  endfunction

endpackage

// File: rtl/vx_dcache_responder_if.sv
// Per-lane dcache request / merged response bundle.
// master = LSU side, slave = responder side.
interface vx_dcache_responder_if;
  import vx_dcache_responder_pkg::*;

  logic [NUM_LANES-1:0]                req_valid;
  logic [NUM_LANES-1:0]                req_rw;
  logic [NUM_LANES-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_LANES-1:0][BYTES_W-1:0]   req_byteen;
  logic [NUM_LANES-1:0][WORD_W-1:0]    req_data;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0] req_tag;
  logic [NUM_LANES-1:0]                req_ready;
  logic [NUM_LANES-1:0]                rsp_valid;
  logic [NUM_LANES-1:0]                rsp_tmask;
  logic [NUM_LANES-1:0][WORD_W-1:0]    rsp_data;
  logic [TAG_WIDTH-1:0]                rsp_tag;
  logic                                rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr,
    output req_byteen, req_data, req_tag,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_tmask,
    input  rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr,
    input  req_byteen, req_data, req_tag,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_tmask,
    output rsp_data, rsp_tag
  );

endinterface

// File: rtl/vx_dcache_responder_fifo.sv
// Response beat queue: registered storage, head visible combinationally.
// Caller guarantees no push when full and no pop when empty.
module vx_dcache_responder_fifo #(
  parameter int DATAW = 8,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty
);

  localparam int PW = $clog2(SIZE);

  logic [DATAW-1:0] mem_q [SIZE];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(push);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end

  assign data_out = mem_q[rd_q];
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/vx_dcache_responder.sv
// Behavioural per-lane local memory answering LSU dcache requests.
// DCRSP_TAG_CHECK_EN adds a simulation check that fired lanes share one tag.
module vx_dcache_responder
  import vx_dcache_responder_pkg::*;
#(
  parameter int WORDS     = 1024,
  parameter int LATENCY   = 2,
  parameter int RSPQ_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_dcache_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CRD_W = $clog2(RSPQ_SIZE) + 1;

  logic [WORD_W-1:0] mem_q [WORDS];

  lmask_t                  fire, rd_fire, wr_fire;
  logic                    credit_ok;
  beat_t [LATENCY-1:0]     pipe_q, pipe_d;
  logic [CRD_W-1:0]        crd_q, crd_d;
  beat_t                   head;
  logic                    empty, present, push, pop;

  // Credits cover beats in the pipe plus the queue, so the queue never overflows.
  assign credit_ok     = crd_q < CRD_W'(RSPQ_SIZE);
  assign bus.req_ready = {NUM_LANES{credit_ok & ~reset}};
  assign fire          = bus.req_valid & bus.req_ready;
  assign rd_fire       = fire & ~bus.req_rw;
  assign wr_fire       = fire & bus.req_rw;

  assign push    = |pipe_q[LATENCY-1].tmask;
  assign present = ~empty & ~reset;
  assign pop     = present & bus.rsp_ready;

  always_comb begin
    pipe_d          = '0;
    pipe_d[0].tmask = rd_fire;
    pipe_d[0].tag   = low_tag(rd_fire, bus.req_tag);
    for (int i = 0; i < NUM_LANES; i++)
      if (rd_fire[i])
        pipe_d[0].data[i] = mem_q[bus.req_addr[i][IDX_W-1:0]];
    for (int k = 1; k < LATENCY; k++)
      pipe_d[k] = pipe_q[k-1];
    crd_d = crd_q + CRD_W'(|rd_fire) - CRD_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
      crd_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      crd_q  <= crd_d;
    end
  end

  // Later lanes win on the same byte; reads above sampled the old word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      for (int b = 0; b < BYTES_W; b++)
        if (wr_fire[i] && bus.req_byteen[i][b])
          mem_q[bus.req_addr[i][IDX_W-1:0]][b*8 +: 8]
            <= bus.req_data[i][b*8 +: 8];
  end

  vx_dcache_responder_fifo #(
    .DATAW ($bits(beat_t)),
    .SIZE  (RSPQ_SIZE)
  ) u_rspq (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (pipe_q[LATENCY-1]),
    .data_out (head),
    .empty    (empty)
  );

  assign bus.rsp_valid = present ? head.tmask : '0;
  assign bus.rsp_tmask = present ? head.tmask : '0;
  assign bus.rsp_data  = present ? head.data  : '0;
  assign bus.rsp_tag   = present ? head.tag   : '0;

`ifdef DCRSP_TAG_CHECK_EN
  always @(posedge clk) begin
    if (!reset)
      for (int i = 0; i < NUM_LANES; i++)
        if (fire[i] && bus.req_tag[i] != low_tag(fire, bus.req_tag))
          $error("%0t lane %0d tag %h vs %h", $time, i,
                 bus.req_tag[i], low_tag(fire, bus.req_tag));
  end
`else
  // Without the check the lowest fired read lane's tag is used as-is.
`endif

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Randomized + directed bench for vx_dcache_responder.
// Reference: word-array memory and a queue of accepted beats.
module tb_vx_dcache_responder;
  import vx_dcache_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_dcache_responder_if bus ();

  vx_dcache_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int           cyc;
    logic [3:0]   tmask;
    logic [7:0]   tag;
    logic [127:0] data;
  } exp_t;

  exp_t         expq[$];
  logic [31:0]  mdl_mem [1024];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           obs_acc = 0;
  logic [3:0]   last_tmask;
  logic [7:0]   last_tag;
  logic [127:0] last_data;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.req_valid  = '0;
    bus.req_rw     = '0;
    bus.req_addr   = '0;
    bus.req_byteen = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
  endtask

  task automatic lane(input int i, input logic rw, input logic [29:0] a,
                      input logic [3:0] be, input logic [31:0] d,
                      input logic [7:0] t);
    bus.req_valid[i]  = 1'b1;
    bus.req_rw[i]     = rw;
    bus.req_addr[i]   = a;
    bus.req_byteen[i] = be;
    bus.req_data[i]   = d;
    bus.req_tag[i]    = t;
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic tick();
    logic       rdy;
    logic [3:0] ev, rdm;
    exp_t       b;
    @(negedge clk);
    rdy = !reset && expq.size() < 4;
    ev  = '0;
    if (!reset && expq.size() > 0 && expq[0].cyc + 3 <= cyc)
      ev = expq[0].tmask;
    check("req_ready", bus.req_ready, {4{rdy}});
    check("rsp_valid", bus.rsp_valid, ev);
    check("rsp_tmask", bus.rsp_tmask, ev);
    if (ev != 0) begin
      check("rsp_data", bus.rsp_data, expq[0].data);
      check("rsp_tag", bus.rsp_tag, expq[0].tag);
    end else begin
      check("rsp_data_idle", bus.rsp_data, '0);
    end
    if (bus.req_ready[0] && bus.req_valid[0] && !bus.req_rw[0])
      obs_acc++;
    if (reset) begin
      expq.delete();
    end else begin
      if (ev != 0 && bus.rsp_ready) begin
        last_tmask = bus.rsp_tmask;
        last_tag   = bus.rsp_tag;
        last_data  = bus.rsp_data;
        void'(expq.pop_front());
      end
      rdm = rdy ? (bus.req_valid & ~bus.req_rw) : 4'h0;
      if (rdm != 0) begin
        b.cyc = cyc; b.tmask = rdm; b.tag = '0; b.data = '0;
        for (int i = 3; i >= 0; i--)
          if (rdm[i]) begin
            b.tag = bus.req_tag[i];
            b.data[i*32 +: 32] = mdl_mem[bus.req_addr[i][9:0]];
          end
        expq.push_back(b);
      end
      if (rdy)
        for (int i = 0; i < 4; i++)
          if (bus.req_valid[i] && bus.req_rw[i])
            for (int k = 0; k < 4; k++)
              if (bus.req_byteen[i][k])
                mdl_mem[bus.req_addr[i][9:0]][k*8 +: 8] = bus.req_data[i][k*8 +: 8];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle(input int n);
    idle();
    repeat (n) tick();
  endtask

  initial begin
    logic [7:0] t;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    idle();
    repeat (2) tick();
    reset = 1'b0;

    // Preload words 0..31, then words 1..4 with known values.
    for (int w = 0; w < 32; w += 4) begin
      idle();
      for (int i = 0; i < 4; i++)
        lane(i, 1'b1, 30'(w + i), 4'hF, $urandom, 8'h0);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++)
      lane(i, 1'b1, 30'(i + 1), 4'hF, 32'((i + 1) * 32'h11), 8'h0);
    tick();

    // Full write then read.
    idle(); lane(0, 1'b1, 30'h10, 4'hF, 32'hDEADBEEF, 8'h0); tick();
    idle(); lane(0, 1'b0, 30'h10, 4'h0, 32'h0, 8'h3); tick();
    settle(3);
    check("t1_data", last_data[31:0], 32'hDEADBEEF);
    check("t1_tmask", last_tmask, 4'b0001);

    // Partial byte write.
    idle(); lane(0, 1'b1, 30'h10, 4'b0010, 32'h0000AA00, 8'h0); tick();
    idle(); lane(0, 1'b0, 30'h10, 4'hF, 32'h0, 8'h1); tick();
    settle(3);
    check("t2_data", last_data[31:0], 32'hDEADAAEF);

    // Four-lane merged read.
    idle();
    for (int i = 0; i < 4; i++) lane(i, 1'b0, 30'(i + 1), 4'h0, 32'h0, 8'h5);
    tick();
    settle(3);
    check("t3_tmask", last_tmask, 4'hF);
    check("t3_tag", last_tag, 8'h5);
    check("t3_data", last_data, 128'h00000044_00000033_00000022_00000011);

    // Same-word collisions.
    idle();
    lane(0, 1'b1, 30'h7, 4'hF, 32'h1, 8'h0);
    lane(1, 1'b1, 30'h8, 4'hF, 32'h88, 8'h0);
    lane(2, 1'b1, 30'h7, 4'hF, 32'h2, 8'h0);
    tick();
    idle();
    lane(0, 1'b0, 30'h7, 4'h0, 32'h0, 8'h9);
    lane(1, 1'b0, 30'h8, 4'h0, 32'h0, 8'h9);
    lane(3, 1'b1, 30'h8, 4'hF, 32'h99, 8'h9);
    tick();
    settle(3);
    check("t5_hi_lane", last_data[31:0], 32'h2);
    check("t5_old", last_data[63:32], 32'h88);
    check("t5_tmask", last_tmask, 4'b0011);

    // Back-pressure: credits cap accepted reads.
    bus.rsp_ready = 1'b0;
    obs_acc = 0;
    for (int c = 0; c < 10; c++) begin
      idle(); lane(0, 1'b0, 30'($urandom_range(0, 31)), 4'h0, 32'h0, 8'(c)); tick();
    end
    check("t4_acc", obs_acc, 4);
    check("t4_ready", bus.req_ready, 4'h0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle(); lane(0, 1'b0, 30'($urandom_range(0, 31)), 4'h0, 32'h0, 8'(c)); tick();
    end
    settle(8);

    // Reset with two beats queued and one in flight.
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle(); lane(1, 1'b0, 30'(c), 4'h0, 32'h0, 8'h7); tick();
    end
    settle(1);
    reset = 1'b1;
    repeat (2) tick();
    check("t6_valid", bus.rsp_valid, 4'h0);
    check("t6_ready", bus.req_ready, 4'h0);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    settle(5);
    idle(); lane(2, 1'b0, 30'h10, 4'h0, 32'h0, 8'h2); tick();
    settle(3);
    check("t6_mem", last_data[95:64], 32'hDEADAAEF);

    // Random traffic with wrapped upper address bits.
    for (int c = 0; c < 300; c++) begin
      idle();
      t = 8'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) != 0)
          lane(i, 1'($urandom),
               (30'($urandom) & 30'h3FFFFC00) | 30'($urandom_range(0, 31)),
               4'($urandom), $urandom, t);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    bus.rsp_ready = 1'b1;
    settle(20);
    check("drain_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
